// File: rtl/bus_handshake_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_handshake_bridge_if
//  Description : Handshake and bus bundle between the clocked bridge, its
//                upstream producer / downstream consumer and the
//                asynchronous stage it drives.
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_handshake_bridge_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2
);
  // Upstream word sink
  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_data;
  // Asynchronous stage buses
  logic [IN_W-1:0]  bus_in;
  logic [OUT_W-1:0] bus_out;
  // Result source
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic [IN_W-1:0]  m_word;
  // Status
  logic             busy;

  // Bridge side
  modport master (
    input  s_valid, s_data, bus_out, m_ready,
    output s_ready, bus_in, m_valid, m_data, m_word, busy
  );

  // Environment side (producer, consumer and downstream stage)
  modport slave (
    output s_valid, s_data, bus_out, m_ready,
    input  s_ready, bus_in, m_valid, m_data, m_word, busy
  );
endinterface
`default_nettype wire

// File: rtl/bus_handshake_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : bus_handshake_bridge
//  Description : Launches words onto the input bus of an asynchronous stage,
//                waits a fixed settle window, samples the synchronised output
//                bus and returns it on a valid/ready source. Optionally
//                inserts an all-zero spacer between words (return-to-zero).
//  Revision    : 1.0  initial release
// ============================================================================
module bus_handshake_bridge #(
  parameter int IN_W        = 3,
  parameter int OUT_W       = 2,
  parameter int SETTLE      = 4,  // must be >= 1
  parameter int SYNC_STAGES = 2,  // must be >= 2
  parameter int RTZ         = 1   // 1 = all-zero spacer after each word
) (
  input  wire logic              clk,
  input  wire logic              rst,
  bus_handshake_bridge_if.master bus
);

  // Full wait window: settle time plus synchroniser latency.
  localparam int c_WIN   = SETTLE + SYNC_STAGES;
  localparam int c_CNT_W = $clog2(c_WIN + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_WIN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SPACER = 2'd3
  } state_t;

  state_t                              r_state;
  logic [c_CNT_W-1:0]                  r_cnt;
  logic                                r_s_ready;
  logic [IN_W-1:0]                     r_bus_in;
  logic                                r_m_valid;
  logic [OUT_W-1:0]                    r_m_data;
  logic [IN_W-1:0]                     r_m_word;
  logic [SYNC_STAGES-1:0][OUT_W-1:0]   r_sync;

  logic                                w_accept;
  logic                                w_release;

  assign w_accept  = bus.s_valid & r_s_ready;
  assign w_release = r_m_valid & bus.m_ready;

  // Synchroniser chain on the asynchronous output bus; only the last stage is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.bus_out};
    end
  end

  // Control FSM: accept, settle, hold result until taken, optional spacer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_s_ready <= 1'b0;
      r_bus_in  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_word  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_bus_in  <= bus.s_data;
            r_m_word  <= bus.s_data;
            r_cnt     <= '0;
            r_s_ready <= 1'b0;
            r_state   <= ST_SETTLE;
          end else begin
            // Ready comes up one edge after reset release and stays up while idle.
            r_s_ready <= 1'b1;
          end
        end

        ST_SETTLE: begin
          if (r_cnt == c_CNT_LAST) begin
            r_m_data  <= r_sync[SYNC_STAGES-1];
            r_m_valid <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_HOLD: begin
          if (w_release) begin
            r_m_valid <= 1'b0;
            if (RTZ != 0) begin
              // Return the stage to its all-low state before the next word.
              r_bus_in <= '0;
              r_cnt    <= '0;
              r_state  <= ST_SPACER;
            end else begin
              r_s_ready <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
        end

        ST_SPACER: begin
          if (r_cnt == c_CNT_LAST) begin
            r_s_ready <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_s_ready <= 1'b0;
          r_bus_in  <= '0;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready = r_s_ready;
  assign bus.bus_in  = r_bus_in;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_word  = r_m_word;
  assign bus.busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_handshake_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_handshake_bridge
//  Description : Directed bench for bus_handshake_bridge, one instance with
//                the return-to-zero spacer and one without. A two-cycle
//                delayed combinational function stands in for the
//                asynchronous stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_handshake_bridge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_handshake_bridge_if #(.IN_W(3), .OUT_W(2)) ifa ();
  bus_handshake_bridge_if #(.IN_W(3), .OUT_W(2)) ifb ();

  bus_handshake_bridge #(.IN_W(3), .OUT_W(2), .SETTLE(4), .SYNC_STAGES(2), .RTZ(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bus_handshake_bridge #(.IN_W(3), .OUT_W(2), .SETTLE(4), .SYNC_STAGES(2), .RTZ(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Downstream stage: out = {x2^x1, x1&x0}, visible two cycles after bus_in changes.
  function automatic logic [1:0] stage_f(input logic [2:0] x);
    return {x[2] ^ x[1], x[1] & x[0]};
  endfunction

  logic [2:0] a_d1 = '0, a_d2 = '0, b_d1 = '0, b_d2 = '0;
  always @(posedge clk) begin
    a_d1 <= ifa.bus_in;
    a_d2 <= a_d1;
    b_d1 <= ifb.bus_in;
    b_d2 <= b_d1;
  end
  assign ifa.bus_out = stage_f(a_d2);
  assign ifb.bus_out = stage_f(b_d2);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.m_ready = 1'b0;
    ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.m_ready = 1'b0;

    // Reset held three cycles, then released
    rst = 1'b1;
    #1;
    chk("rst_bus_in", 8'(ifa.bus_in), 8'h0);
    repeat (3) step();
    chk("rst_s_ready", 8'(ifa.s_ready), 8'h0);
    chk("rst_m_valid", 8'(ifa.m_valid), 8'h0);
    chk("rst_busy", 8'(ifa.busy), 8'h0);
    rst = 1'b0;
    #2;
    chk("rel_s_ready_pre", 8'(ifa.s_ready), 8'h0);
    step();
    chk("idle_s_ready", 8'(ifa.s_ready), 8'h1);
    chk("idle_bus_in", 8'(ifa.bus_in), 8'h0);
    chk("idle_m_valid", 8'(ifa.m_valid), 8'h0);
    chk("idle_busy", 8'(ifa.busy), 8'h0);
    chk("idle_b_s_ready", 8'(ifb.s_ready), 8'h1);

    // Single word 101 with backpressure
    ifa.s_valid = 1'b1; ifa.s_data = 3'b101; ifa.m_ready = 1'b0;
    step();                                   // edge 0: accept
    ifa.s_valid = 1'b0;
    chk("acc_bus_in", 8'(ifa.bus_in), 8'h5);
    chk("acc_s_ready", 8'(ifa.s_ready), 8'h0);
    chk("acc_busy", 8'(ifa.busy), 8'h1);
    repeat (5) step();                        // edge 5
    chk("settle_m_valid", 8'(ifa.m_valid), 8'h0);
    chk("settle_bus_in", 8'(ifa.bus_in), 8'h5);
    step();                                   // edge 6
    chk("res1_m_valid", 8'(ifa.m_valid), 8'h1);
    chk("res1_m_data", 8'(ifa.m_data), 8'h2);
    chk("res1_m_word", 8'(ifa.m_word), 8'h5);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_m_valid", 8'(ifa.m_valid), 8'h1);
      chk("bp_m_data", 8'(ifa.m_data), 8'h2);
      chk("bp_m_word", 8'(ifa.m_word), 8'h5);
      chk("bp_bus_in", 8'(ifa.bus_in), 8'h5);
      chk("bp_s_ready", 8'(ifa.s_ready), 8'h0);
    end
    ifa.m_ready = 1'b1;
    step();                                   // HOLD exit
    ifa.m_ready = 1'b0;
    chk("bp_exit_m_valid", 8'(ifa.m_valid), 8'h0);
    chk("bp_exit_bus_in", 8'(ifa.bus_in), 8'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("spacer_s_ready", 8'(ifa.s_ready), 8'h0);
      chk("spacer_bus_in", 8'(ifa.bus_in), 8'h0);
    end
    step();
    chk("spacer_done_s_ready", 8'(ifa.s_ready), 8'h1);
    chk("spacer_done_busy", 8'(ifa.busy), 8'h0);

    // Back-to-back 011 then 110, RTZ=1, consumer always ready
    ifa.m_ready = 1'b1; ifa.s_valid = 1'b1; ifa.s_data = 3'b011;
    step();                                   // edge 0
    ifa.s_data = 3'b110;
    repeat (6) step();                        // edge 6
    chk("b2b1_m_valid", 8'(ifa.m_valid), 8'h1);
    chk("b2b1_m_data", 8'(ifa.m_data), 8'h3);
    chk("b2b1_m_word", 8'(ifa.m_word), 8'h3);
    step();                                   // edge 7
    chk("b2b1_drop", 8'(ifa.m_valid), 8'h0);
    chk("b2b1_rtz", 8'(ifa.bus_in), 8'h0);
    repeat (5) step();                        // edge 12
    chk("b2b_gap_s_ready", 8'(ifa.s_ready), 8'h0);
    step();                                   // edge 13
    chk("b2b_gap_done", 8'(ifa.s_ready), 8'h1);
    step();                                   // edge 14: second accept
    ifa.s_valid = 1'b0;
    chk("b2b2_bus_in", 8'(ifa.bus_in), 8'h6);
    chk("b2b2_s_ready", 8'(ifa.s_ready), 8'h0);
    repeat (6) step();                        // edge 20
    chk("b2b2_m_valid", 8'(ifa.m_valid), 8'h1);
    chk("b2b2_m_data", 8'(ifa.m_data), 8'h0);
    chk("b2b2_m_word", 8'(ifa.m_word), 8'h6);
    step();                                   // edge 21
    chk("b2b2_drop", 8'(ifa.m_valid), 8'h0);

    // Same pair on the RTZ=0 instance
    ifb.m_ready = 1'b1; ifb.s_valid = 1'b1; ifb.s_data = 3'b011;
    step();                                   // edge 0
    ifb.s_data = 3'b110;
    repeat (6) step();                        // edge 6
    chk("nrz1_m_valid", 8'(ifb.m_valid), 8'h1);
    chk("nrz1_m_data", 8'(ifb.m_data), 8'h3);
    step();                                   // edge 7
    chk("nrz1_drop", 8'(ifb.m_valid), 8'h0);
    chk("nrz1_s_ready", 8'(ifb.s_ready), 8'h1);
    chk("nrz1_no_spacer", 8'(ifb.bus_in), 8'h3);
    step();                                   // edge 8: second accept
    ifb.s_valid = 1'b0;
    chk("nrz2_bus_in", 8'(ifb.bus_in), 8'h6);
    chk("nrz2_m_word", 8'(ifb.m_word), 8'h6);
    repeat (6) step();                        // edge 14
    chk("nrz2_m_valid", 8'(ifb.m_valid), 8'h1);
    chk("nrz2_m_data", 8'(ifb.m_data), 8'h0);
    step();                                   // edge 15
    chk("nrz2_s_ready", 8'(ifb.s_ready), 8'h1);

    // All-zero word, then 010 presented during SETTLE (ignored until idle)
    ifa.s_valid = 1'b1; ifa.s_data = 3'b000;
    step();                                   // edge 0
    ifa.s_data = 3'b010;
    step();                                   // edge 1
    chk("ign_s_ready", 8'(ifa.s_ready), 8'h0);
    chk("ign_m_word", 8'(ifa.m_word), 8'h0);
    chk("ign_busy", 8'(ifa.busy), 8'h1);
    repeat (5) step();                        // edge 6
    chk("zero_m_valid", 8'(ifa.m_valid), 8'h1);
    chk("zero_m_data", 8'(ifa.m_data), 8'h0);
    repeat (6) step();                        // edge 12
    chk("zero_spacer", 8'(ifa.s_ready), 8'h0);
    step();                                   // edge 13
    chk("zero_spacer_done", 8'(ifa.s_ready), 8'h1);
    step();                                   // edge 14: 010 accepted
    ifa.s_valid = 1'b0;
    chk("ign_acc_bus_in", 8'(ifa.bus_in), 8'h2);
    repeat (6) step();                        // edge 20
    chk("ign_res_m_valid", 8'(ifa.m_valid), 8'h1);
    chk("ign_res_m_data", 8'(ifa.m_data), 8'h2);
    chk("ign_res_m_word", 8'(ifa.m_word), 8'h2);
    repeat (7) step();                        // edge 27: idle again

    // Reset three cycles into SETTLE with word 111
    ifa.s_valid = 1'b1; ifa.s_data = 3'b111;
    step();                                   // edge 0
    ifa.s_valid = 1'b0;
    repeat (3) step();
    chk("mid_bus_in_pre", 8'(ifa.bus_in), 8'h7);
    rst = 1'b1;
    #1;
    chk("mid_bus_in", 8'(ifa.bus_in), 8'h0);
    chk("mid_m_valid", 8'(ifa.m_valid), 8'h0);
    chk("mid_s_ready", 8'(ifa.s_ready), 8'h0);
    chk("mid_busy", 8'(ifa.busy), 8'h0);
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("mid_rel_s_ready", 8'(ifa.s_ready), 8'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mid_no_result", 8'(ifa.m_valid), 8'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
